// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD engine arbiter.
package gcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int GCD_W       = 8;
  localparam int GCD_TIMEOUT = 1023;
  localparam int CNT_W       = 16;

endpackage

// File: rtl/gcd_arbiter_rr_pick.sv
// Round-robin winner search: first asserted request at or above ptr, modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // Walk from the farthest slot back toward ptr so the nearest hit is written last.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[wrap_add(ptr, k)]) idx = wrap_add(ptr, k);
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin scheduler sharing one GCD engine among N requesters,
// with zero-operand bypass and a WAIT watchdog.
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int N           = 4,
  parameter int W           = GCD_W,
  parameter int TIMEOUT_CYC = GCD_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       a_in,
  input  logic [N*W-1:0]       b_in,
  output logic [N-1:0]         ack,
  output logic [W-1:0]         res_out,
  output logic                 res_valid,
  output logic [$clog2(N)-1:0] res_id,
  output logic                 res_err,
  output logic                 busy,
  output logic                 err_sticky,
  output logic                 eng_go,
  output logic [W-1:0]         eng_in1,
  output logic [W-1:0]         eng_in2,
  input  logic [W-1:0]         eng_out,
  input  logic                 eng_done
);

  localparam int IW = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    idx_q;
  logic [CNT_W-1:0] cnt;

  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic [W-1:0]     a_sel;
  logic [W-1:0]     b_sel;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    a_sel = a_in[int'(pick_idx) * W +: W];
    b_sel = b_in[int'(pick_idx) * W +: W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      idx_q      <= '0;
      cnt        <= '0;
      ack        <= '0;
      res_out    <= '0;
      res_valid  <= 1'b0;
      res_id     <= '0;
      res_err    <= 1'b0;
      busy       <= 1'b0;
      err_sticky <= 1'b0;
      eng_go     <= 1'b0;
      eng_in1    <= '0;
      eng_in2    <= '0;
    end else begin
      case (state)
        // A stuck-high done from the engine holds off any new issue.
        ST_IDLE: begin
          if (pick_valid && !eng_done) begin
            idx_q <= pick_idx;
            busy  <= 1'b1;
            if (a_sel == '0 || b_sel == '0) begin
              res_out   <= a_sel | b_sel;
              res_err   <= 1'b0;
              ack       <= N'(1) << pick_idx;
              res_valid <= 1'b1;
              res_id    <= pick_idx;
              state     <= ST_RESP;
            end else begin
              eng_in1 <= a_sel;
              eng_in2 <= b_sel;
              eng_go  <= 1'b1;
              state   <= ST_ISSUE;
            end
          end
        end

        ST_ISSUE: begin
          eng_go <= 1'b0;
          cnt    <= '0;
          state  <= ST_WAIT;
        end

        // done is checked before the watchdog so a coincident done still succeeds.
        ST_WAIT: begin
          if (eng_done) begin
            res_out   <= eng_out;
            res_err   <= 1'b0;
            ack       <= N'(1) << idx_q;
            res_valid <= 1'b1;
            res_id    <= idx_q;
            state     <= ST_RESP;
          end else if (cnt == CNT_LAST) begin
            res_out    <= '0;
            res_err    <= 1'b1;
            err_sticky <= 1'b1;
            ack        <= N'(1) << idx_q;
            res_valid  <= 1'b1;
            res_id     <= idx_q;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_RESP: begin
          ack       <= '0;
          res_valid <= 1'b0;
          res_err   <= 1'b0;
          busy      <= 1'b0;
          ptr       <= (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
          state     <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter with a small behavioural GCD engine.
module tb_gcd_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   ack;
  logic [W-1:0]   res_out;
  logic           res_valid;
  logic [1:0]     res_id;
  logic           res_err;
  logic           busy;
  logic           err_sticky;
  logic           eng_go;
  logic [W-1:0]   eng_in1;
  logic [W-1:0]   eng_in2;
  logic [W-1:0]   eng_out;
  logic           eng_done;

  logic           hang;
  logic           stuck;
  logic           done_m;
  logic           run_m;
  logic [3:0]     ecnt;
  logic [W-1:0]   result_m;

  int checks = 0;
  int errors = 0;
  int cyc;
  int gos;

  always #5 clk = ~clk;

  gcd_arbiter #(.N(N), .W(W), .TIMEOUT_CYC(1023)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .a_in       (a_in),
    .b_in       (b_in),
    .ack        (ack),
    .res_out    (res_out),
    .res_valid  (res_valid),
    .res_id     (res_id),
    .res_err    (res_err),
    .busy       (busy),
    .err_sticky (err_sticky),
    .eng_go     (eng_go),
    .eng_in1    (eng_in1),
    .eng_in2    (eng_in2),
    .eng_out    (eng_out),
    .eng_done   (eng_done)
  );

  function automatic logic [W-1:0] gcd_f(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] a, b, t;
    a = x;
    b = y;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Engine model: fixed compute delay, one-cycle done pulse; hang never finishes.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_m   <= 1'b0;
      run_m    <= 1'b0;
      ecnt     <= '0;
      result_m <= '0;
    end else begin
      done_m <= 1'b0;
      if (eng_go && !hang) begin
        run_m    <= 1'b1;
        ecnt     <= 4'd3;
        result_m <= gcd_f(eng_in1, eng_in2);
      end else if (run_m) begin
        if (ecnt == 0) begin
          done_m <= 1'b1;
          run_m  <= 1'b0;
        end else begin
          ecnt <= ecnt - 1'b1;
        end
      end
    end
  end

  assign eng_done = done_m | stuck;
  assign eng_out  = result_m;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_until_valid(input string tag, input int budget, output int c, output int g);
    c = 0;
    g = 0;
    do begin
      tick();
      c++;
      if (eng_go) g++;
    end while (!res_valid && c < budget);
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 32'({ack, res_valid, res_id, res_err, busy, err_sticky, eng_go}), 32'd0);
    chk({tag, "_data"}, 32'({res_out, eng_in1, eng_in2}), 32'd0);
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  initial begin
    logic [W-1:0] exp_res [4];
    exp_res[0] = 8'd4;
    exp_res[1] = 8'd3;
    exp_res[2] = 8'd7;
    exp_res[3] = 8'd25;

    rst   = 1'b0;
    req   = '0;
    a_in  = '0;
    b_in  = '0;
    hang  = 1'b0;
    stuck = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    @(negedge clk) rst = 1'b1;
    tick();

    // Single request through the engine.
    set_ops(0, 8'd48, 8'd18);
    req = 4'b0001;
    run_until_valid("single", 20, cyc, gos);
    chk("single_latency", cyc, 7);
    chk("single_go_count", gos, 1);
    chk("single_ops", {eng_in1, eng_in2}, {8'd48, 8'd18});
    chk("single_ack", 32'(ack), 32'b0001);
    chk("single_res", 32'(res_out), 32'd6);
    chk("single_id_err", 32'({res_id, res_err}), 32'd0);
    req = '0;
    tick();
    chk("single_after", 32'({res_valid, ack, busy}), 32'd0);

    // Full load from reset release, twice to cover pointer wrap.
    rst = 1'b0;
    tick();
    set_ops(0, 8'd12, 8'd8);
    set_ops(1, 8'd9, 8'd6);
    set_ops(2, 8'd35, 8'd21);
    set_ops(3, 8'd100, 8'd75);
    req = 4'b1111;
    @(negedge clk) rst = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < N; k++) begin
        run_until_valid($sformatf("rr%0d_%0d", r, k), 20, cyc, gos);
        chk($sformatf("rr%0d_%0d_id", r, k), 32'(res_id), k);
        chk($sformatf("rr%0d_%0d_ack", r, k), 32'(ack), 32'(1) << k);
        chk($sformatf("rr%0d_%0d_res", r, k), 32'(res_out), 32'(exp_res[k]));
        req[k] = 1'b0;
      end
      tick();
      req = 4'b1111;
    end
    req = '0;

    // Zero-operand bypass never touches the engine.
    set_ops(2, 8'd0, 8'd35);
    req = 4'b0100;
    run_until_valid("zero_a", 20, cyc, gos);
    chk("zero_a_latency", cyc, 1);
    chk("zero_a_go", gos, 0);
    chk("zero_a_ack", 32'(ack), 32'b0100);
    chk("zero_a_res", 32'(res_out), 32'd35);
    req = '0;
    tick();
    set_ops(2, 8'd0, 8'd0);
    req = 4'b0100;
    run_until_valid("zero_ab", 20, cyc, gos);
    chk("zero_ab_latency", cyc, 1);
    chk("zero_ab_res", 32'({res_out, res_id}), 32'({8'd0, 2'd2}));
    req = '0;
    tick();

    // Watchdog timeout on a hung engine.
    hang = 1'b1;
    set_ops(0, 8'd48, 8'd18);
    req = 4'b0001;
    run_until_valid("tmo", 1100, cyc, gos);
    chk("tmo_latency", cyc, 1025);
    chk("tmo_err", 32'({res_err, err_sticky}), 32'b11);
    chk("tmo_res", 32'(res_out), 32'd0);
    chk("tmo_ack", 32'(ack), 32'b0001);
    req = '0;
    hang = 1'b0;
    tick();
    set_ops(1, 8'd9, 8'd6);
    req = 4'b0010;
    run_until_valid("post_tmo", 20, cyc, gos);
    chk("post_tmo_res", 32'(res_out), 32'd3);
    chk("post_tmo_err", 32'({res_err, err_sticky}), 32'b01);
    req = '0;
    tick();

    // Asynchronous reset while the engine is busy.
    hang = 1'b1;
    set_ops(0, 8'd12, 8'd8);
    req = 4'b0001;
    tick();
    tick();
    tick();
    chk("midwait_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk_all_zero("midwait_reset");
    req = 4'b1010;
    set_ops(1, 8'd9, 8'd6);
    set_ops(3, 8'd35, 8'd21);
    hang = 1'b0;
    tick();
    chk("midwait_no_ack", 32'({ack, res_valid}), 32'd0);
    @(negedge clk) rst = 1'b1;
    run_until_valid("post_rst_a", 20, cyc, gos);
    chk("post_rst_a_id", 32'({res_id, res_out}), 32'({2'd1, 8'd3}));
    req[1] = 1'b0;
    run_until_valid("post_rst_b", 20, cyc, gos);
    chk("post_rst_b_id", 32'({res_id, res_out}), 32'({2'd3, 8'd7}));
    req = '0;
    tick();

    // Stuck-high done blocks issue until it drops.
    stuck = 1'b1;
    set_ops(0, 8'd100, 8'd75);
    req = 4'b0001;
    gos = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (eng_go) gos++;
    end
    chk("stuck_idle", 32'({busy, 1'b0}), 32'd0);
    chk("stuck_go", gos, 0);
    stuck = 1'b0;
    tick();
    chk("stuck_release_go", 32'({eng_go, eng_in1, eng_in2}), 32'({1'b1, 8'd100, 8'd75}));
    run_until_valid("stuck_done", 20, cyc, gos);
    chk("stuck_done_res", 32'({ack, res_out}), 32'({4'b0001, 8'd25}));
    req = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gcd_arbiter.md
Name: gcd_arbiter

Overview:
- Round-robin scheduler that shares one gcd_machine engine (go/in1/in2 in, out/done back) among N requesters.
- Latches the granted requester's operands and pulses the engine's go.
- Waits for done, then returns the result with a per-requester ack pulse.
- Handles zero operands without the engine and guards against a hung engine with a watchdog.

Parameters:
- N, 4, number of requesters (2..8)
- W, 8, operand/result width; must match the engine
- TIMEOUT_CYC, 1023, max cycles in WAIT before abort; 16-bit counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- req  in  N  per-requester request level
- a_in  in  N*W  requester i operand A at bits [i*W +: W]
- b_in  in  N*W  requester i operand B at bits [i*W +: W]
- ack  out  N  one-cycle completion pulse, one-hot
- res_out  out  W  result, valid while res_valid=1
- res_valid  out  1  result-valid pulse, coincident with ack
- res_id  out  clog2(N)  index of the requester being acked
- res_err  out  1  high with res_valid when the request timed out
- busy  out  1  high in any state other than IDLE
- err_sticky  out  1  set on any timeout; cleared only by reset
- eng_go  out  1  engine start, one-cycle pulse
- eng_in1  out  W  engine operand 1, held from ISSUE through WAIT
- eng_in2  out  W  engine operand 2, held from ISSUE through WAIT
- eng_out  in  W  engine result
- eng_done  in  1  engine completion level

Behaviour:
- Reset (rst=0, async): state=IDLE; rr pointer=0.
  - All outputs 0: ack, res_out, res_valid, res_id, res_err, busy, err_sticky, eng_go, eng_in1, eng_in2.
  - Timeout counter=0.
  - Reset in any state aborts the in-flight request with no ack.
- States: IDLE, ISSUE, WAIT, RESP; encoding is in the package.
- IDLE:
  - Grant only if some req=1 and eng_done=0. A stuck-high done blocks issue.
  - Winner = first i with req[i]=1, searching from the pointer upward modulo N.
  - On the edge: latch idx, A, B.
    - If A==0 or B==0: res_out = A|B (so gcd(0,0)=0), go directly to RESP; the engine is never started.
    - Otherwise: eng_in1=A, eng_in2=B, go to ISSUE.
- ISSUE: eng_go=1 for exactly this cycle. Next edge: WAIT, counter cleared.
- WAIT:
  - Each edge: if eng_done=1, res_out<=eng_out, res_err<=0, go to RESP.
  - Else counter++. When the counter reaches TIMEOUT_CYC-1 with done still low: res_out<=0, res_err<=1, err_sticky<=1, go to RESP.
  - Done on the same edge as the timeout threshold: done wins (no error).
- RESP:
  - ack[idx]=1, res_valid=1, res_id=idx for one cycle.
  - Next edge: IDLE, pointer=(idx+1) mod N (wraps N-1→0).
- Latency:
  - Zero-bypass: grant edge to ack = 1 cycle; ack is high in the cycle after the IDLE cycle that saw req.
  - Normal: ack appears 3 cycles + engine compute time after req is sampled.
- Requester contract:
  - Hold req and operands stable until ack.
  - Drop req on the edge where ack is seen.
  - The arbiter samples req only in IDLE. Operand changes after grant are ignored (latched).
- Boundaries:
  - Req deasserted after grant: the request still completes and acks (no cancel).
  - Back-to-back requests under full load: every requester is served within N transactions (fairness).
  - eng_in1/eng_in2 keep their last values in IDLE/RESP; nothing is required of them there.
- Width rules: no arithmetic on data besides OR for the bypass. res_id is zero-extended index.

Decomposition:
- gcd_pkg holds the state enum/localparams (IDLE, ISSUE, WAIT, RESP) and the default widths W and TIMEOUT_CYC.
- One combinational sub-module, rr_pick: inputs req[N] and pointer; outputs valid and idx.
- Timer, FSM and latches live in gcd_arbiter. A top ties gcd_arbiter to gcd_machine (rst polarity adapted at top).

Test Plan:
- Single request: req0, A=48, B=18 → eng_go one pulse with in1=48/in2=18; ack[0] and res_valid once; res_out=6, res_id=0, res_err=0.
- All four requests held from reset release, operands (12,8), (9,6), (35,21), (100,75) → acks in order 0,1,2,3 with results 4, 3, 7, 25. Then re-assert all: order 0,1,2,3 again (pointer wraps).
- Zero bypass: req2 with A=0, B=35 → eng_go never high; ack[2] exactly 1 cycle after grant; res_out=35. Then A=0, B=0 → res_out=0.
- Timeout: engine model holds done=0 → after 1023 WAIT cycles, res_valid=1, res_err=1, res_out=0, err_sticky=1. A following normal request gets res_err=0 while err_sticky stays 1.
- Reset mid-WAIT: assert rst=0 asynchronously → all outputs 0 immediately, no ack. After release, pointer=0 and req1+req3 pending → req1 served first.
- eng_done stuck high while req0 pending → stays IDLE, no eng_go. Drop done → grant within 1 cycle.
